// File: rtl/starflux_pkg.sv
// starflux_pkg: shared screen geometry, colours, ship bitmap and renderer FSM states.
// Contents: SCREEN_W/H, SHIP_W/H, COLOUR_W and colour constants, SHIP_X_MAX,
// SHIP_BITMAP (row-major, bit 7 = leftmost pixel), ship_draw_state_t, clamp_x().
package starflux_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int SHIP_W = 8;
   localparam int SHIP_H = 8;
   localparam int COLOUR_W = 3;
   localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
   localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;
   localparam logic [7:0] SHIP_X_MAX = 8'(SCREEN_W - SHIP_W);
   localparam logic [0:7][7:0] SHIP_BITMAP = {
      8'b00011000,
      8'b00011000,
      8'b00111100,
      8'b01111110,
      8'b11111111,
      8'b11111111,
      8'b11011011,
      8'b10000001
   };
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ERASE, ST_DRAW, ST_DONE} ship_draw_state_t;
   function automatic logic [7:0] clamp_x(input logic [7:0] x);
      return (x > SHIP_X_MAX) ? SHIP_X_MAX : x;
   endfunction
endpackage

// File: rtl/ship_sprite_rom.sv
// ship_sprite_rom: combinational 8x8 ship bitmap lookup.
// Ports: px, py (sprite-local column/row) -> pixel (1 = ship pixel set).
module ship_sprite_rom
   import starflux_pkg::*;
(
   input  logic [2:0] px,
   input  logic [2:0] py,
   output logic       pixel
);
   always_comb pixel = SHIP_BITMAP[py][3'd7 - px];
endmodule

// File: rtl/user_ship_renderer.sv
// user_ship_renderer: erases and redraws the 8x8 player ship on frame ticks when its column changes.
// Ports: clock, reset (sync, active-high); x_val ship column; frame_tick redraw check;
// grant/req pixel-port handshake; x_out, y_out, colour, plot pixel write; done redraw pulse.
// Build option: SHIP_SPRITE_EN selects the arrow bitmap instead of a solid block.
module user_ship_renderer
   import starflux_pkg::*;
#(
   parameter logic [6:0]          SHIP_Y      = 7'd112,
   parameter logic [COLOUR_W-1:0] SHIP_COLOUR = COL_WHITE,
   parameter logic [COLOUR_W-1:0] BG_COLOUR   = COL_BLACK
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          x_val,
   input  logic                frame_tick,
   input  logic                grant,
   output logic                req,
   output logic [7:0]          x_out,
   output logic [6:0]          y_out,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                done
);
   ship_draw_state_t state;
   logic [7:0] drawn_x, tgt_x, x_eff;
   logic dirty, last, erasing, sprite_bit;
   logic [2:0] px, py;
   logic [COLOUR_W-1:0] draw_colour;
`ifdef SHIP_SPRITE_EN
   ship_sprite_rom rom (.px(px), .py(py), .pixel(sprite_bit));
`else
   assign sprite_bit = 1'b1;
`endif
   always_comb begin
      x_eff = clamp_x(x_val);
      last = px == 3'd7 && py == 3'd7;
      erasing = state != ST_DRAW;
      draw_colour = sprite_bit ? SHIP_COLOUR : BG_COLOUR;
   end
   // Outputs are registered, so a granted cycle emits the pixel under the counters
   // into the next cycle; REQ with grant already emits erase pixel (0,0).
   // A high done marks the completion cycle, during which ticks are still ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         drawn_x <= '0;
         tgt_x <= '0;
         dirty <= 1'b1;
         px <= '0;
         py <= '0;
         req <= 1'b0;
         plot <= 1'b0;
         done <= 1'b0;
         x_out <= '0;
         y_out <= '0;
         colour <= '0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         case (state)
            ST_IDLE: if (frame_tick && !done && (x_eff != drawn_x || dirty)) begin
               tgt_x <= x_eff;
               px <= '0;
               py <= '0;
               req <= 1'b1;
               state <= ST_REQ;
            end
            ST_REQ, ST_ERASE, ST_DRAW: if (grant) begin
               plot <= 1'b1;
               x_out <= (erasing ? drawn_x : tgt_x) + {5'd0, px};
               y_out <= SHIP_Y + {4'd0, py};
               colour <= erasing ? BG_COLOUR : draw_colour;
               {py, px} <= {py, px} + 6'd1;
               if (state == ST_REQ) state <= ST_ERASE;
               else if (last) state <= (state == ST_ERASE) ? ST_DRAW : ST_DONE;
               if (last && state == ST_DRAW) begin
                  drawn_x <= tgt_x;
                  dirty <= 1'b0;
               end
            end
            default: begin
               req <= 1'b0;
               done <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_user_ship_renderer.sv
// tb_user_ship_renderer: randomized self-checking bench for user_ship_renderer against a pixel-list model.
module tb_user_ship_renderer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       grant = 1'b0;
   logic [7:0] x_val = 8'd0;
   logic       req, plot, done;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   int checks = 0;
   int failures = 0;
   logic [7:0]  drawn_m = 8'd0;
   logic        dirty_m = 1'b1;
   logic [17:0] exp_q[$];
`ifdef SHIP_SPRITE_EN
   logic [7:0] rows [8] = '{8'b00011000, 8'b00011000, 8'b00111100, 8'b01111110,
                            8'b11111111, 8'b11111111, 8'b11011011, 8'b10000001};
`endif

   always #10 clock = ~clock;

   user_ship_renderer dut (
      .clock(clock), .reset(reset), .x_val(x_val), .frame_tick(frame_tick), .grant(grant),
      .req(req), .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .done(done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic idle_watch(input string tag, input int n);
      bit bad = 0;
      repeat (n) begin
         @(negedge clock);
         if (req || plot || done) bad = 1;
      end
      check_eq(tag, {31'd0, bad}, 0);
   endtask

   // One tick at column x; a stall of stall_len grant-low cycles starts once
   // stall_at pixels have been seen; optional poke re-ticks and changes x_val mid-redraw.
   task automatic run_redraw(input logic [7:0] x, input int stall_at, input int stall_len,
                             input int idle_n, input bit poke, input logic [7:0] x2);
      logic [7:0] tgt;
      logic [2:0] c;
      bit exp_draw;
      int nplot, done_cyc, left;
      tgt = (x > 8'd152) ? 8'd152 : x;
      exp_draw = (tgt != drawn_m) || dirty_m;
      @(negedge clock);
      x_val = x;
      frame_tick = 1'b1;
      grant = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      check_eq("req_t1", {31'd0, req}, {31'd0, exp_draw});
      if (!exp_draw) begin
         idle_watch("no_redraw", idle_n);
         return;
      end
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back({drawn_m + 8'(i % 8), 7'(112 + i / 8), 3'b000});
      for (int i = 0; i < 64; i++) begin
`ifdef SHIP_SPRITE_EN
         c = rows[i / 8][7 - i % 8] ? 3'b111 : 3'b000;
`else
         c = 3'b111;
`endif
         exp_q.push_back({tgt + 8'(i % 8), 7'(112 + i / 8), c});
      end
      nplot = 0;
      done_cyc = -1;
      left = 0;
      for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
         @(negedge clock);
         if (plot) begin
            if (exp_q.size() == 0) check_eq("extra_plot", {31'd0, plot}, 0);
            else check_eq("pix", {14'd0, x_out, y_out, colour}, {14'd0, exp_q.pop_front()});
            check_eq("x_max", {31'd0, x_out <= 8'd159}, 1);
            nplot++;
            if (nplot == stall_at) left = stall_len;
         end
         if (k == 64) check_eq("req_mid", {31'd0, req}, 1);
         if (done) begin
            done_cyc = k;
            check_eq("req_done", {31'd0, req}, 0);
         end
         if (poke && k == 50) begin
            frame_tick = 1'b1;
            x_val = x2;
         end else frame_tick = 1'b0;
         grant = (left == 0);
         if (left > 0) left--;
      end
      frame_tick = 1'b0;
      grant = 1'b1;
      check_eq("plots", nplot, 128);
      check_eq("done_cyc", done_cyc, 129 + stall_len);
      drawn_m = tgt;
      dirty_m = 1'b0;
      idle_watch("post_idle", idle_n);
   endtask

   initial begin
      int cnt;
      logic [7:0] rx;
      repeat (3) @(negedge clock);
      check_eq("rst_req", {31'd0, req}, 0);
      check_eq("rst_plot", {31'd0, plot}, 0);
      check_eq("rst_done", {31'd0, done}, 0);
      check_eq("rst_xyc", {14'd0, x_out, y_out, colour}, 0);
      reset = 1'b0;
      run_redraw(8'd0, 0, 0, 5, 0, 8'd0);
      run_redraw(8'd0, 0, 0, 200, 0, 8'd0);
      run_redraw(8'd160, 0, 0, 5, 0, 8'd0);
      run_redraw(8'd10, 0, 0, 5, 0, 8'd0);
      run_redraw(8'd20, 30, 5, 5, 0, 8'd0);
      run_redraw(8'd40, 0, 0, 5, 1, 8'd90);
      run_redraw(8'd90, 0, 0, 5, 0, 8'd0);
      @(negedge clock);
      x_val = 8'd120;
      frame_tick = 1'b1;
      grant = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      cnt = 0;
      for (int k = 0; k < 300 && cnt < 80; k++) begin
         @(negedge clock);
         if (plot) cnt++;
      end
      check_eq("reached_draw", cnt, 80);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_eq("mid_rst_req", {31'd0, req}, 0);
      check_eq("mid_rst_plot", {31'd0, plot}, 0);
      drawn_m = 8'd0;
      dirty_m = 1'b1;
      run_redraw(8'd120, 0, 0, 5, 0, 8'd0);
      for (int n = 0; n < 20; n++) begin
         rx = ($urandom_range(3) == 0) ? drawn_m : 8'($urandom_range(160));
         run_redraw(rx, $urandom_range(127, 1), $urandom_range(6), 10, 0, 8'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/user_ship_renderer.md
# user_ship_renderer

Draws the player ship into the VGA adapter's frame buffer at the horizontal position produced by the user movement handler. On each frame tick where the ship position has changed, the block:
- requests the shared pixel port,
- erases the ship at its previously drawn column,
- redraws it at the new column.

It sits between the movement handler's `x_val` output and the pixel-port arbiter in front of the 160×120 VGA adapter.

## Interface
Parameters:
- `SHIP_Y`, 7'd112: top row of the ship sprite.
- `SHIP_COLOUR`, 3'b111: colour of set sprite pixels.
- `BG_COLOUR`, 3'b000: erase colour, also used for clear sprite pixels.

Ports:
- `clock`  in  1: 50 MHz system clock. One clock only.
- `reset`  in  1: synchronous, active-high reset.
- `x_val`  in  8: ship column from the movement handler, range 0..160.
- `frame_tick`  in  1: one-cycle pulse per frame; starts a redraw check.
- `grant`  in  1: arbiter grant for the pixel port.
- `req`  out  1: pixel-port request.
- `x_out`  out  8: pixel column.
- `y_out`  out  7: pixel row.
- `colour`  out  3: pixel colour.
- `plot`  out  1: pixel write strobe.
- `done`  out  1: one-cycle pulse when a redraw completes.

## Operation
- Sprite size is fixed at 8×8.
- Effective column: `x_eff = min(x_val, 152)`. The ship is never drawn past column 159.
- Registered state:
  - `drawn_x` (8 bits): column of the ship currently on screen.
  - `dirty` (1 bit): set by reset; forces the first draw even if the column is unchanged.
  - `tgt_x` (8 bits): target column.
  - `px`, `py` (3 bits each): pixel counters.
- FSM states:
  - **IDLE**: on `frame_tick` with (`x_eff != drawn_x` or `dirty`), latch `tgt_x = x_eff` and go to REQ. Otherwise stay in IDLE.
  - **REQ**: `req=1`. When `grant=1`, clear `px`/`py` and go to ERASE.
  - **ERASE**: each granted cycle, plot (`drawn_x+px`, `SHIP_Y+py`) in `BG_COLOUR`. Raster order: `px` increments, wraps 7→0, then `py` increments. After pixel (7,7), go to DRAW with counters cleared.
  - **DRAW**: same scan at `tgt_x`. Colour is `SHIP_COLOUR` where the sprite bit is 1, else `BG_COLOUR`. `plot=1` for all 64 pixels. After (7,7), set `drawn_x = tgt_x`, clear `dirty`, go to DONE.
  - **DONE**: `done=1` and `req=0` for one cycle, then go to IDLE.
- `req` stays high from REQ through the last DRAW pixel.
- `grant` low during ERASE or DRAW stalls the scan: `plot=0` and counters hold. The scan resumes at the same pixel when `grant` returns.
- `frame_tick` outside IDLE is ignored and is not queued.
- `x_val` changes after latching do not affect the current redraw. They are picked up on the next tick.
- Coordinates never wrap: `px` ≤ 7 and `tgt_x` ≤ 152, so `x_out` ≤ 159. Row 112+7 = 119.

## Timing
- Reset values: `req=0`, `plot=0`, `done=0`, `x_out=0`, `y_out=0`, `colour=0`, state IDLE, `drawn_x=0`, `dirty=1`.
- All outputs are registered. `x_out`/`y_out`/`colour` are valid in the same cycle as `plot=1`.
- Tick accepted in cycle T → `req=1` in cycle T+1.
- `grant` seen high in cycle G → first ERASE plot in G+1.
- Uninterrupted redraw: 128 plot cycles (G+1..G+128), then `done` in G+129.
- Reset asserted mid-redraw: next cycle is IDLE with reset values. The partially drawn image is left as-is and fully redrawn on the next tick because `dirty=1`.

## Configuration
- `SHIP_SPRITE_EN` defined: DRAW colour comes from the 8×8 ship bitmap (arrow shape).
- `SHIP_SPRITE_EN` undefined: every DRAW pixel is `SHIP_COLOUR` (solid 8×8 block). The ROM is not instantiated.
- Timing and cycle counts are identical in both builds.

## Structure
- Shared package `starflux_pkg`:
  - `SCREEN_W=160`, `SCREEN_H=120`, `SHIP_W=8`, `SHIP_H=8`.
  - Colour width 3 and colour constants.
  - FSM state enum `ship_draw_state_t`.
- Sub-module `ship_sprite_rom`: combinational lookup, (`px`, `py`) → 1-bit pixel. Instantiated only under `SHIP_SPRITE_EN`.

## Test plan
- Reset, `x_val=0`, one tick, `grant` held at 1 → `req` at T+1; 64 erase plots at x 0..7, y 112..119, colour 0; then 64 draw plots; `done` at G+129; `drawn_x=0`.
- Tick with unchanged `x_val=0` after the first draw → no `req`, no `plot` for 200 cycles.
- `x_val=160`, tick → draw columns 152..159; no `x_out` > 159 ever observed.
- `x_val` 10→20, tick, `grant` dropped for 5 cycles during erase pixel 30 → `plot=0` for 5 cycles; pixel 30 replayed at (10+6, 115); 128 plots total; `done` delayed by 5 cycles.
- Tick during a redraw, and `x_val` changed mid-redraw → extra tick ignored; current draw uses the latched column; next tick redraws at the new column.
- `reset` asserted mid-DRAW → next cycle `req=0`, `plot=0`; the following tick performs a full redraw despite an unchanged `x_val`.
